// File: rtl/soc_sysid_checker.sv
// Boot-time system-ID checker: reads the sysid slave words repeatedly, compares and reports.
// Optional SYSID_CHECK_AUTOSTART_EN: runs one check on the first edge after reset release.
//
// state    | meaning
// IDLE     | waiting for start (or autostart)
// RD_ID    | reading address 0 SAMPLES times
// RD_TS    | reading address 1 SAMPLES times
// CHECK    | one cycle to form the pass/fail flags
// DONE     | results valid, holding until next start
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h622A_31A2,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned SAMPLES            = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        sysid_stable
);

  localparam logic [3:0] WAIT_RELOAD = 4'(READ_LATENCY - 1);
  localparam logic [2:0] LAST_SAMPLE = 3'(SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  sample_cnt_q, sample_cnt_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        stable_q, stable_d;
  logic        start_eff;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // Set by reset, consumed by the first clock edge after release.
  logic auto_pend_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_pend_q <= 1'b1;
    else          auto_pend_q <= 1'b0;
  end

  assign start_eff = start | auto_pend_q;
`else
  assign start_eff = start;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      sample_cnt_q <= 3'd0;
      addr_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      id_value_q   <= 32'd0;
      ts_value_q   <= 32'd0;
      id_ok_q      <= 1'b0;
      ts_ok_q      <= 1'b0;
      stable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      id_value_q   <= id_value_d;
      ts_value_q   <= ts_value_d;
      id_ok_q      <= id_ok_d;
      ts_ok_q      <= ts_ok_d;
      stable_q     <= stable_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    sample_cnt_d = sample_cnt_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    id_value_d   = id_value_q;
    ts_value_d   = ts_value_q;
    id_ok_d      = id_ok_q;
    ts_ok_d      = ts_ok_q;
    stable_d     = stable_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_eff) begin
          state_d      = ST_RD_ID;
          done_d       = 1'b0;
          id_ok_d      = 1'b0;
          ts_ok_d      = 1'b0;
          stable_d     = 1'b1;
          busy_d       = 1'b1;
          addr_d       = 1'b0;
          wait_cnt_d   = WAIT_RELOAD;
          sample_cnt_d = 3'd0;
        end
      end

      ST_RD_ID: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          // First sample is the reference; later ones only vote on stability.
          if (sample_cnt_q == 3'd0) id_value_d = sysid_readdata;
          else if (sysid_readdata != id_value_q) stable_d = 1'b0;
          wait_cnt_d = WAIT_RELOAD;
          if (sample_cnt_q == LAST_SAMPLE) begin
            sample_cnt_d = 3'd0;
            addr_d       = 1'b1;
            state_d      = ST_RD_TS;
          end else begin
            sample_cnt_d = sample_cnt_q + 3'd1;
          end
        end
      end

      ST_RD_TS: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          if (sample_cnt_q == 3'd0) ts_value_d = sysid_readdata;
          else if (sysid_readdata != ts_value_q) stable_d = 1'b0;
          wait_cnt_d = WAIT_RELOAD;
          if (sample_cnt_q == LAST_SAMPLE) begin
            sample_cnt_d = 3'd0;
            addr_d       = 1'b0;
            state_d      = ST_CHECK;
          end else begin
            sample_cnt_d = sample_cnt_q + 3'd1;
          end
        end
      end

      ST_CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID) & stable_q;
        ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP) & stable_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sysid_address   = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_value        = id_value_q;
  assign timestamp_value = ts_value_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign sysid_stable    = stable_q;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Randomized self-checking bench for soc_sysid_checker: two instances (default timing and
// READ_LATENCY=3/SAMPLES=1) driven by a sample-schedule slave model and a word-level reference.
module tb_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h622A_31A2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start [2];
  logic [31:0] rdata [2];
  logic        addr  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] idv   [2];
  logic [31:0] tsv   [2];
  logic        idok  [2];
  logic        tsok  [2];
  logic        stab  [2];

  // Per-run slave contents: vals[word][sample index]
  logic [31:0] vals [2][8];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  soc_sysid_checker u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]),
    .sysid_address(addr[0]), .sysid_readdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .id_value(idv[0]), .timestamp_value(tsv[0]),
    .id_ok(idok[0]), .ts_ok(tsok[0]), .sysid_stable(stab[0])
  );

  soc_sysid_checker #(.READ_LATENCY(3), .SAMPLES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[1]),
    .sysid_address(addr[1]), .sysid_readdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .id_value(idv[1]), .timestamp_value(tsv[1]),
    .id_ok(idok[1]), .ts_ok(tsok[1]), .sysid_stable(stab[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input int d, input string tag);
    chk({tag, " addr"},   32'(addr[d]), 32'd0);
    chk({tag, " busy"},   32'(busy[d]), 32'd0);
    chk({tag, " done"},   32'(done[d]), 32'd0);
    chk({tag, " id_v"},   idv[d],       32'd0);
    chk({tag, " ts_v"},   tsv[d],       32'd0);
    chk({tag, " id_ok"},  32'(idok[d]), 32'd0);
    chk({tag, " ts_ok"},  32'(tsok[d]), 32'd0);
    chk({tag, " stable"}, 32'(stab[d]), 32'd0);
  endtask

  task automatic set_ideal();
    for (int k = 0; k < 8; k++) begin
      vals[0][k] = EXP_ID;
      vals[1][k] = EXP_TS;
    end
  endtask

  task automatic rand_vals(input int s);
    logic [31:0] first;
    for (int w = 0; w < 2; w++) begin
      if ($urandom_range(0, 1) == 0) first = (w == 0) ? EXP_ID : EXP_TS;
      else first = $urandom;
      for (int k = 0; k < 8; k++) begin
        if (k > 0 && k < s && $urandom_range(0, 3) == 0)
          vals[w][k] = first ^ (32'h1 << $urandom_range(0, 31));
        else
          vals[w][k] = first;
      end
    end
  endtask

  // One full check: reference from the word arrays, slave serves vals by schedule.
  task automatic run_check(input int d, input int rl, input int s, input string tag);
    int          last;
    int          p;
    logic [31:0] e_id, e_ts;
    logic        e_st, e_idok, e_tsok;
    last = 2 * rl * s + 1;
    e_id = vals[0][0];
    e_ts = vals[1][0];
    e_st = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < s; k++)
        if (vals[w][k] != vals[w][0]) e_st = 1'b0;
    e_idok = (e_id == EXP_ID) && e_st;
    e_tsok = (e_ts == EXP_TS) && e_st;

    @(negedge clock);
    start[d] = 1'b1;
    @(negedge clock);
    start[d] = 1'b0;
    for (int n = 1; n <= last; n++) begin
      chk({tag, " busy_run"}, 32'(busy[d]), 32'd1);
      chk({tag, " done_run"}, 32'(done[d]), 32'd0);
      if (n < last) begin
        p = (n - 1) / rl;
        chk({tag, " addr_run"}, 32'(addr[d]), 32'(p / s));
        rdata[d] = vals[int'(addr[d])][p % s];
      end else begin
        chk({tag, " addr_chk"}, 32'(addr[d]), 32'd0);
        rdata[d] = $urandom;
      end
      start[d] = ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    start[d] = 1'b0;
    for (int h = 0; h < 2; h++) begin
      chk({tag, " done"},   32'(done[d]), 32'd1);
      chk({tag, " busy"},   32'(busy[d]), 32'd0);
      chk({tag, " id_v"},   idv[d],       e_id);
      chk({tag, " ts_v"},   tsv[d],       e_ts);
      chk({tag, " stable"}, 32'(stab[d]), 32'(e_st));
      chk({tag, " id_ok"},  32'(idok[d]), 32'(e_idok));
      chk({tag, " ts_ok"},  32'(tsok[d]), 32'(e_tsok));
      @(negedge clock);
    end
  endtask

  // Called at the negedge where reset_n was just released.
  task automatic post_reset(input string tag);
`ifdef SYSID_CHECK_AUTOSTART_EN
    @(negedge clock);
    chk({tag, " auto busy0"}, 32'(busy[0]), 32'd1);
    chk({tag, " auto busy1"}, 32'(busy[1]), 32'd1);
    repeat (4) @(negedge clock);
    chk({tag, " auto pre done0"}, 32'(done[0]), 32'd0);
    @(negedge clock);
    chk({tag, " auto done0"}, 32'(done[0]), 32'd1);
    chk({tag, " auto pre done1"}, 32'(done[1]), 32'd0);
    repeat (2) @(negedge clock);
    chk({tag, " auto done1"}, 32'(done[1]), 32'd1);
`else
    repeat (4) begin
      @(negedge clock);
      chk({tag, " idle busy0"}, 32'(busy[0]), 32'd0);
      chk({tag, " idle busy1"}, 32'(busy[1]), 32'd0);
      chk({tag, " idle done0"}, 32'(done[0]), 32'd0);
    end
`endif
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      rdata[d] = 32'd0;
    end
    set_ideal();

    #12;
    chk_all_zero(0, "rst0");
    chk_all_zero(1, "rst1");
    @(negedge clock);
    reset_n = 1'b1;
    post_reset("rel1");

    set_ideal();
    run_check(0, 1, 2, "ideal0");
    set_ideal();
    vals[1][0] = 32'h622A_31A3;
    vals[1][1] = 32'h622A_31A3;
    run_check(0, 1, 2, "ts_bad");
    set_ideal();
    vals[1][1] = EXP_TS ^ 32'h1;
    run_check(0, 1, 2, "ts_flip");
    set_ideal();
    run_check(1, 3, 1, "ideal1");
    vals[0][0] = 32'h0000_0001;
    run_check(1, 3, 1, "id_bad1");

    for (int r = 0; r < 12; r++) begin
      rand_vals(2);
      run_check(0, 1, 2, "rnd0");
      rand_vals(1);
      run_check(1, 3, 1, "rnd1");
    end

    // Reset in the middle of RD_TS
    set_ideal();
    @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid addr_ts", 32'(addr[0]), 32'd1);
    chk("mid busy", 32'(busy[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero(0, "mid0");
    chk_all_zero(1, "mid1");
    @(negedge clock);
    chk_all_zero(0, "mid0b");
    reset_n = 1'b1;
    post_reset("rel2");

    set_ideal();
    run_check(0, 1, 2, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/soc_sysid_checker.md
# soc_sysid_checker

Boot-time sequencer that sits directly upstream of the SoC system-ID slave. It drives that slave's 1-bit `address`, samples its 32-bit `readdata`, and captures the system ID word (address 0) and the build timestamp word (address 1). Each word is compared against an expected value and checked for stability across repeated reads. The block then reports pass/fail flags for reset-release logic or a status register.

## Interface

Parameters:
- `EXPECTED_ID`, default 0: expected system ID word (address 0).
- `EXPECTED_TIMESTAMP`, default 1646932386 (0x622A31A2): expected timestamp word (address 1).
- `READ_LATENCY`, default 1, legal 1..15: cycles `sysid_address` is held stable before each sample.
- `SAMPLES`, default 2, legal 1..7: number of reads per word.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run a check.
- `sysid_address`  out  1  address driven to the sysid slave.
- `sysid_readdata`  in  32  read data from the sysid slave.
- `busy`  out  1  check in progress.
- `done`  out  1  level; results valid.
- `id_value`  out  32  first sample of address 0.
- `timestamp_value`  out  32  first sample of address 1.
- `id_ok`  out  1  ID matches `EXPECTED_ID` and is stable.
- `ts_ok`  out  1  timestamp matches `EXPECTED_TIMESTAMP` and is stable.
- `sysid_stable`  out  1  every sample equalled the first sample of its word.

## Operation

- FSM states: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE or DONE, `start`=1 → RD_ID.
  - Clears `done`, `id_ok`, `ts_ok`.
  - Sets `sysid_stable`=1, `busy`=1, `sysid_address`=0.
  - Loads wait counter = READ_LATENCY-1 and sample counter = 0.
- RD_ID:
  - Wait counter decrements each cycle.
  - At 0: sample `sysid_readdata`.
    - Sample 0 loads `id_value`.
    - Later samples clear `sysid_stable` if they differ from `id_value`.
  - Sample counter increments and the wait counter reloads.
  - After SAMPLES samples → RD_TS with `sysid_address`=1.
- RD_TS: same procedure into `timestamp_value`. After SAMPLES samples → CHECK with `sysid_address`=0.
- CHECK (1 cycle):
  - `id_ok` = (`id_value`==EXPECTED_ID) & `sysid_stable`.
  - `ts_ok` = (`timestamp_value`==EXPECTED_TIMESTAMP) & `sysid_stable`.
  - → DONE.
- DONE: `done`=1, `busy`=0. Results hold until the next `start`.
- `start` while `busy`=1 is ignored: no restart, no queueing.
- Comparisons are full 32-bit equality. Counters are 4 bits (wait) and 3 bits (sample) and never wrap within legal parameter ranges.
- Results and values are all 32-bit unsigned, with no arithmetic beyond the counters.

## Timing

- Reset values:
  - `sysid_address`=0, `busy`=0, `done`=0.
  - `id_value`=0, `timestamp_value`=0.
  - `id_ok`=0, `ts_ok`=0, `sysid_stable`=0.
  - State = IDLE.
- `sysid_readdata` is treated as valid READ_LATENCY cycles after `sysid_address` changes. Sampling occurs on the edge ending the READ_LATENCY-th cycle.
- Latency: `start` sampled at edge 0 → `done` high after edge 2·READ_LATENCY·SAMPLES+1.
  - READ_LATENCY=1, SAMPLES=2: `done` after edge 5.
- `busy` is high from the edge after `start` until the edge `done` rises. `busy` and `done` are never both high.
- `start` in the same cycle that DONE is entered is ignored: the state was CHECK.
- Reset asserted mid-check: all outputs return immediately (asynchronously) to reset values. No partial results survive.

## Configuration

- `SYSID_CHECK_AUTOSTART_EN` defined:
  - The first rising edge after `reset_n` deasserts behaves as `start`=1, so a check runs once per reset without software.
  - `start` still re-runs the check later.
- Not defined: the FSM stays in IDLE until `start`. No autostart logic is built.

## Test plan

- Model slave: readdata = address ? 0x622A31A2 : 0. Pulse `start` with defaults → `done` after edge 5, `id_ok`=1, `ts_ok`=1, `sysid_stable`=1, `timestamp_value`=0x622A31A2.
- Slave returns 0x622A31A3 at address 1 → `ts_ok`=0, `id_ok`=1, `sysid_stable`=1, `timestamp_value`=0x622A31A3.
- Slave flips bit 0 of the timestamp on the second sample (SAMPLES=2) → `sysid_stable`=0, `id_ok`=0, `ts_ok`=0, `timestamp_value`=0x622A31A2.
- READ_LATENCY=3, SAMPLES=1:
  - `sysid_address` holds 0 for 3 cycles, then 1 for 3 cycles.
  - `done` after edge 7.
  - `start` pulses during `busy` are ignored.
- Assert `reset_n`=0 in the middle of RD_TS → all outputs read 0 in the same cycle, state IDLE. With `SYSID_CHECK_AUTOSTART_EN`, `busy`=1 on the first edge after release and `done` after edge 5; without it, `busy` stays 0.
